uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
Shares one 8N1 UART transmit line between NREQ byte producers, such as the flag dumper, debug console and status reporter. A round-robin arbiter grants one requester per frame, latches its byte and serialises it. Bit timing comes from the existing 16x-oversample tick pulse produced by the baud generator. Sits between the firmware-facing producers and the board TX pin.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of owner index; NREQ <= 2**IDW
DBIT, 8, data bits per frame, sent LSB first
SB_TICK, 16, ticks per stop bit (16 = 1 stop bit, 32 = 2 stop bits)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
tick  in  1  one-cycle pulse at 16x baud, from the baud generator
req  in  NREQ  req[i] high = requester i has a byte pending
din  in  NREQ*DBIT  byte of requester i is din[i*DBIT +: DBIT]
ack  out  NREQ  one-cycle pulse: byte of requester i latched
owner  out  IDW  index of requester whose frame is on the line
busy  out  1  high from grant until stop bit completes
tx  out  1  serial output, idle high

Behaviour:
- Reset (sync, active-high) is sampled on the rising clk edge. After that edge:
  - tx=1, busy=0, ack=0, owner=0, state=IDLE.
  - Round-robin pointer = NREQ-1, so req[0] has highest priority first.
- Every output comes from a register. There are no combinational paths from inputs to outputs.
- FSM states: IDLE, START, DATA, STOP, PARITY (PARITY exists only with the macro).
- Counters:
  - s_cnt: 4 bits, counts ticks within a bit.
  - n_cnt: counts data bits, 0..DBIT-1.
  - s_cnt advances only on cycles where tick=1.
- IDLE, any req high at edge n:
  - Grant goes to the first i with req[i]=1, searching i = ptr+1, ptr+2, ... modulo NREQ.
  - On edge n the block latches din[i] into the shift register, sets ptr=i and owner=i.
  - ack[i]=1 for cycle n+1 only.
  - busy=1 and tx=0 from cycle n+1.
  - s_cnt is cleared and the FSM moves to START. START is not aligned to tick.
- IDLE with no req: tx=1, busy=0. tick is ignored.
- START: after 16 ticks, move to DATA, set n_cnt=0 and drive tx = shift register bit 0.
- DATA: every 16 ticks, shift right. After bit DBIT-1, move to STOP (or PARITY when enabled).
- STOP: tx=1. After SB_TICK ticks, move to IDLE with busy=0 on the same edge.
- Minimum one IDLE cycle between frames. Back-to-back frames have a gap of 1 clk plus the tick phase.
- Requester handshake:
  - Hold req and din stable until ack.
  - din is sampled only on the grant edge. Changes before the grant are invisible.
  - Changes after ack do not affect the frame in flight.
  - A req dropped before grant is simply not served. No pending state is stored.
  - A req still high after ack is treated as a new byte and is eligible at the next IDLE.
- Fairness: with all requesters continuously asserting, grants rotate 0,1,...,NREQ-1,0.
  - No requester waits more than NREQ-1 frames.
- Reset mid-frame: the frame is truncated, tx=1 on the next edge, and no ack is issued.
- A tick coincident with the grant edge is not counted (s_cnt is cleared that edge).
- owner holds its last value while in IDLE.

Optional Feature:
Macro: UART_TX_PARITY_EN
- Defined:
  - After DATA, the FSM enters PARITY for 16 ticks.
  - tx = XOR of the latched DBIT bits (even parity), then STOP.
  - Frame is 1+DBIT+1 bits plus stop.
- Undefined: the PARITY state, its logic and parity register are absent. DATA goes straight to STOP.

Test Plan:
- Reset check: reset high 3 cycles with req=4'b1111 -> tx=1, busy=0, ack=0000, owner=0 throughout; release -> first ack=0001 one cycle later.
- Single byte: req[2]=1, din[2]=8'hA5, tick every 4 clk:
  - ack=0100 for exactly 1 cycle, owner=2.
  - tx = 0, 1,0,1,0,0,1,0,1 (LSB first), 1, each bit 16 ticks = 64 clk.
  - busy falls after 640 clk.
- Round robin: req=1111 held with distinct bytes 8'h11/22/33/44 -> ack order 0,1,2,3,0 and matching bytes on tx.
- Priority rotation: after a grant to 1, assert req=1011 -> next grant 3, then 0, then 1.
- Reset mid-DATA: reset pulse at bit 4 of 8'hFF frame -> tx=1 next edge, busy=0; next req[0] is granted with a full fresh frame.
- Parity (macro defined): din=8'h07 -> parity bit 1 between bit7 and stop; din=8'h03 -> parity bit 0.

Source files
------------

// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if: producer-side request/byte bus, bit tick and serial line of the TX scheduler
interface uart_tx_scheduler_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int DBIT = 8
);
  logic                 tick;
  logic [NREQ-1:0]      req;
  logic [NREQ*DBIT-1:0] din;
  logic [NREQ-1:0]      ack;
  logic [IDW-1:0]       owner;
  logic                 busy;
  logic                 tx;
  modport master (output tick, req, din, input ack, owner, busy, tx);
  modport slave  (input tick, req, din, output ack, owner, busy, tx);
endinterface

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin share of one 8N1 UART TX line between NREQ producers (UART_TX_PARITY_EN adds even parity)
module uart_tx_scheduler #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_tx_scheduler_if.slave   bus
);
  localparam int SW = SB_TICK > 16 ? $clog2(SB_TICK) : 4;
  localparam int NW = DBIT > 1 ? $clog2(DBIT) : 1;
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
`ifdef UART_TX_PARITY_EN
    , PARITY
`endif
  } state_t;
  state_t          state, state_n;
  logic [SW-1:0]   s_cnt, s_n;
  logic [NW-1:0]   n_cnt, n_n;
  logic [DBIT-1:0] sh, sh_n;
  logic [IDW-1:0]  ptr, ptr_n, owner_n, gnt, cand;
  logic [NREQ-1:0] ack_n;
  logic            busy_n, tx_n, gnt_ok, bit_end;
`ifdef UART_TX_PARITY_EN
  logic            par, par_n;
`endif
  // scan from the highest offset down so the nearest requester after ptr wins
  always_comb begin
    gnt_ok = 1'b0;
    gnt = '0;
    cand = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (bus.req[cand]) begin
        gnt_ok = 1'b1;
        gnt = cand;
      end
    end
  end
  always_comb begin
    state_n = state;
    s_n = s_cnt;
    n_n = n_cnt;
    sh_n = sh;
    ptr_n = ptr;
    owner_n = bus.owner;
    ack_n = '0;
    busy_n = bus.busy;
    tx_n = bus.tx;
`ifdef UART_TX_PARITY_EN
    par_n = par;
`endif
    bit_end = bus.tick && s_cnt == SW'(15);
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        busy_n = 1'b0;
        if (gnt_ok) begin
          state_n = START;
          s_n = '0;
          sh_n = bus.din[gnt*DBIT +: DBIT];
          ptr_n = gnt;
          owner_n = gnt;
          ack_n[gnt] = 1'b1;
          busy_n = 1'b1;
          tx_n = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_n = ^bus.din[gnt*DBIT +: DBIT];
`endif
        end
      end
      START: begin
        s_n = bus.tick ? s_cnt + 1'b1 : s_cnt;
        if (bit_end) begin
          state_n = DATA;
          s_n = '0;
          n_n = '0;
          tx_n = sh[0];
        end
      end
      DATA: begin
        s_n = bus.tick ? s_cnt + 1'b1 : s_cnt;
        if (bit_end) begin
          s_n = '0;
          sh_n = sh >> 1;
          n_n = n_cnt + 1'b1;
          tx_n = sh[1];
          if (n_cnt == NW'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            tx_n = par;
`else
            state_n = STOP;
            tx_n = 1'b1;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        s_n = bus.tick ? s_cnt + 1'b1 : s_cnt;
        if (bit_end) begin
          state_n = STOP;
          s_n = '0;
          tx_n = 1'b1;
        end
      end
`endif
      STOP: begin
        tx_n = 1'b1;
        s_n = bus.tick ? s_cnt + 1'b1 : s_cnt;
        if (bus.tick && s_cnt == SW'(SB_TICK - 1)) begin
          state_n = IDLE;
          s_n = '0;
          busy_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      s_cnt <= '0;
      n_cnt <= '0;
      sh <= '0;
      ptr <= IDW'(NREQ - 1);
      bus.owner <= '0;
      bus.ack <= '0;
      bus.busy <= 1'b0;
      bus.tx <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      state <= state_n;
      s_cnt <= s_n;
      n_cnt <= n_n;
      sh <= sh_n;
      ptr <= ptr_n;
      bus.owner <= owner_n;
      bus.ack <= ack_n;
      bus.busy <= busy_n;
      bus.tx <= tx_n;
`ifdef UART_TX_PARITY_EN
      par <= par_n;
`endif
    end
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: table-driven frame checks plus reset sequences for uart_tx_scheduler
module tb_uart_tx_scheduler;
  localparam int NREQ = 4, IDW = 2, DBIT = 8;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int TOT = 16 * (DBIT + 2 + PB);
  logic clk = 0, reset = 1;
  int nchk = 0, nerr = 0, tcnt = 0;
  uart_tx_scheduler_if #(.NREQ(NREQ), .IDW(IDW), .DBIT(DBIT)) bus ();
  uart_tx_scheduler #(.NREQ(NREQ), .IDW(IDW), .DBIT(DBIT), .SB_TICK(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    bus.tick = 0;
    forever begin
      @(negedge clk);
      tcnt++;
      bus.tick = (tcnt % 4 == 0);
    end
  end
  typedef struct {
    logic [3:0]  req;
    logic [31:0] din;
    int          idx;
    logic [7:0]  b;
  } vec_t;
  vec_t vt[12];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic run_frame(input int idx, input logic [7:0] b, output int waited);
    int t, p;
    bit first;
    waited = 0;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (bus.ack == 0 && waited < 40);
    check("ack", 32'(bus.ack), 32'(1 << idx));
    check("owner", 32'(bus.owner), 32'(idx));
    check("busy_on", 32'(bus.busy), 1);
    check("start_tx", 32'(bus.tx), 0);
    if (bus.ack == 0) return;
    t = 0;
    first = 1;
    while (t < TOT) begin
      @(posedge clk); #1;
      if (first) check("ack_pulse", 32'(bus.ack), 0);
      first = 0;
      if (bus.tick) begin
        t++;
        p = t / 16;
        if (t % 16 == 8) begin
          if (p == 0) check("start_bit", 32'(bus.tx), 0);
          else if (p <= DBIT) check($sformatf("data_bit%0d", p - 1), 32'(bus.tx), 32'(b[p-1]));
          else if (p == DBIT + 1 && PB == 1) check("parity_bit", 32'(bus.tx), 32'(^b));
          else check("stop_bit", 32'(bus.tx), 1);
        end
        if (t == TOT - 1) check("busy_hold", 32'(bus.busy), 1);
        if (t == TOT) begin
          check("busy_off", 32'(bus.busy), 0);
          check("idle_tx", 32'(bus.tx), 1);
        end
      end
    end
  endtask
  initial begin
    int w, t;
    vt[0]  = '{4'b1111, 32'h44332211, 0, 8'h11};
    vt[1]  = '{4'b1111, 32'h44332211, 1, 8'h22};
    vt[2]  = '{4'b1111, 32'h44332211, 2, 8'h33};
    vt[3]  = '{4'b1111, 32'h44332211, 3, 8'h44};
    vt[4]  = '{4'b1111, 32'h44332211, 0, 8'h11};
    vt[5]  = '{4'b0010, 32'h44332211, 1, 8'h22};
    vt[6]  = '{4'b1011, 32'h44332211, 3, 8'h44};
    vt[7]  = '{4'b1011, 32'h44332211, 0, 8'h11};
    vt[8]  = '{4'b1011, 32'h44332211, 1, 8'h22};
    vt[9]  = '{4'b0100, 32'h44A52211, 2, 8'hA5};
    vt[10] = '{4'b0001, 32'h00000007, 0, 8'h07};
    vt[11] = '{4'b0001, 32'h00000003, 0, 8'h03};
    bus.req = 4'b1111;
    bus.din = 32'h44332211;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_tx", 32'(bus.tx), 1);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_ack", 32'(bus.ack), 0);
      check("rst_owner", 32'(bus.owner), 0);
    end
    reset = 0;
    for (int i = 0; i < 12; i++) begin
      bus.req = vt[i].req;
      bus.din = vt[i].din;
      run_frame(vt[i].idx, vt[i].b, w);
      if (i == 0) check("rst_first_ack_latency", 32'(w), 1);
    end
    bus.req = 4'b0001;
    bus.din = 32'h000000FF;
    w = 0;
    do begin
      @(posedge clk); #1;
      w++;
    end while (bus.ack == 0 && w < 40);
    check("mid_ack", 32'(bus.ack), 1);
    bus.req = 0;
    t = 0;
    while (t < 16 * 5 + 8) begin
      @(posedge clk); #1;
      if (bus.tick) t++;
    end
    check("mid_busy", 32'(bus.busy), 1);
    reset = 1;
    @(posedge clk); #1;
    check("mid_rst_tx", 32'(bus.tx), 1);
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_ack", 32'(bus.ack), 0);
    reset = 0;
    @(posedge clk); #1;
    check("post_rst_ack", 32'(bus.ack), 0);
    check("post_rst_busy", 32'(bus.busy), 0);
    bus.req = 4'b0001;
    bus.din = 32'h0000005A;
    run_frame(0, 8'h5A, w);
    bus.req = 0;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
